mem_ram_init: RTL and testbench
===============================

// Module: mem_ram_init
// PURPOSE
//  Parametrised single-port synchronous RAM with a built-in preload sequencer.
//  After reset, or on a Clear request, it writes a program image from the shared
//  package into the array one word per cycle. It then serves single-cycle reads
//  and writes to the datapath.
//  Sits between the control unit and the datapath as program/data memory; it
//  generalises the fixed 32x8 preloaded RAM to any width and depth.
// PARAMETERS
//  DATA_W    8   word width in bits
//  ADDR_W    5   address width in bits
//  DEPTH     32  number of words, must be <= 2**ADDR_W
//  INIT_LEN  18  number of image words taken from the package image, must be <= DEPTH
//  ZERO_FILL 1   1: words INIT_LEN..DEPTH-1 are written 0 during init; 0: left untouched
// PORTS
//  Clock    in  1       single clock; all state updates on the rising edge
//  In       in  1       asynchronous active-low reset
//  Clear    in  1       synchronous request to re-run the preload
//  Req      in  1       access request, sampled only in RUN
//  WE       in  1       1 = write, 0 = read (qualified by Req)
//  Address  in  ADDR_W  word address
//  D        in  DATA_W  write data
//  Q        out DATA_W  read data, registered
//  QValid   out 1       Q updated by a read issued on the previous cycle
//  Busy     out 1       high while the preload sequencer owns the array
//  Reject   out 1       one-cycle pulse: the previous cycle's Req was dropped
// BEHAVIOUR
//  Reset (In=0, async): state=INIT, ptr=0, Q=0, QValid=0, Busy=1, Reject=0.
//   Array contents are not reset; the preload overwrites them.
//  States:
//   INIT:
//    - each cycle writes mem[ptr] = img(ptr) if ptr<INIT_LEN, else 0.
//    - then ptr++.
//    - last word is DEPTH-1 (ZERO_FILL=1) or INIT_LEN-1 (ZERO_FILL=0); the
//      edge that writes it moves to RUN and drops Busy.
//    - preload lasts DEPTH (or INIT_LEN) cycles after In rises.
//   RUN:
//    - Req&!WE: Q<=mem[Address], QValid=1 next cycle (latency 1).
//    - Req&WE: mem[Address]<=D; QValid=0, Q holds.
//    - !Req: QValid=0, Q holds its last value.
//  Transitions: INIT->RUN on last preload word; RUN->INIT on Clear.
//   Clear in INIT restarts with ptr=0.
//  Priority: In > Clear > Req.
//   A Req in the same cycle as Clear is dropped and Reject pulses next cycle.
//  Req while Busy: no array access, QValid=0, Reject=1 next cycle. Q holds.
//  Address >= DEPTH (when DEPTH < 2**ADDR_W):
//   - write is discarded;
//   - read returns Q=0 with QValid=1;
//   - Reject=1 for both cases.
//  Read-after-write: a read of an address written the previous cycle returns the
//   new data. No same-cycle read/write exists (single port).
//  Reset asserted mid-preload or mid-access: immediate return to reset values;
//   preload restarts from ptr=0 when In rises.
//  Widths: ptr is ADDR_W+1 bits so the end compare never wraps. D/Q are unsigned
//   and not extended or truncated.
// STRUCTURE
//  Package mem_ram_pkg:
//   - state encoding constants (INIT, RUN);
//   - function img(idx) returning the default program image.
//   - img for indices 0..17: 80 3E 80 3F 1E 7F B0 CC 1F 7E 3F C4 1E 7F 3E C4 1E FF;
//     indices >= 18 return 0.
//  Sub-module mem_ram_core:
//   - plain DEPTH x DATA_W array: one write port and one registered read port;
//   - no reset.
//   - Top level muxes its write port between the sequencer and the user.
// TESTING
//  1. In 0->1, defaults: Busy high for exactly 32 cycles, then read addr 1 ->
//     Q=0x3E with QValid=1 one cycle later; read 17 -> 0xFF; read 30 -> 0x00.
//  2. Write 0x5A to addr 4, read addr 4 the next cycle -> Q=0x5A.
//     Then assert Clear, wait for Busy low, read addr 4 -> 0x1E.
//  3. Req=1 read during INIT -> Reject=1 for one cycle, QValid=0, Q unchanged.
//     Clear and Req asserted together in RUN -> Req dropped, Reject=1.
//  4. DEPTH=24, ADDR_W=5: write 0x77 to addr 28 -> Reject=1; read addr 28 ->
//     Q=0, QValid=1, Reject=1. Read addr 20 -> 0x00 (zero-filled).
//  5. Pull In low at preload cycle 10 and release: Busy stays high for a full
//     32 cycles from release; addr 0 reads 0x80.
//  6. ZERO_FILL=0: Busy high for 18 cycles; back-to-back reads of addrs 0..3
//     -> 80,3E,80,3F with QValid high every cycle.

Source files
------------

// File: rtl/mem_ram_pkg.sv
// Shared definitions for the preloaded RAM: sequencer states and the default program image.
package mem_ram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int IMG_LEN = 18;

    function automatic logic [7:0] img(input int unsigned idx);
        case (idx)
            0:       return 8'h80;
            1:       return 8'h3E;
            2:       return 8'h80;
            3:       return 8'h3F;
            4:       return 8'h1E;
            5:       return 8'h7F;
            6:       return 8'hB0;
            7:       return 8'hCC;
            8:       return 8'h1F;
            9:       return 8'h7E;
            10:      return 8'h3F;
            11:      return 8'hC4;
            12:      return 8'h1E;
            13:      return 8'h7F;
            14:      return 8'h3E;
            15:      return 8'hC4;
            16:      return 8'h1E;
            17:      return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/mem_ram_init_if.sv
// Access bus between the control unit (master) and the preloaded RAM (slave).
interface mem_ram_init_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              Clear;
    logic              Req;
    logic              WE;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] D;
    logic [DATA_W-1:0] Q;
    logic              QValid;
    logic              Busy;
    logic              Reject;

    modport master (
        output Clear, Req, WE, Address, D,
        input  Q, QValid, Busy, Reject
    );

    modport slave (
        input  Clear, Req, WE, Address, D,
        output Q, QValid, Busy, Reject
    );
endinterface

// File: rtl/mem_ram_core.sv
// Plain DEPTH x DATA_W storage array with one write port and one registered read port.
module mem_ram_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              Clock,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: no reset on the array or its read register, so it maps onto RAM macros;
    // the preload sequencer supplies the defined contents instead.
    always_ff @(posedge Clock) begin
        // NOTE: non-blocking assignments keep read-before-write ordering between
        // clocked processes independent of simulator scheduling.
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_ram_init.sv
// Single-port synchronous RAM that preloads the package image after reset or Clear.
module mem_ram_init
    import mem_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 32,
    parameter int INIT_LEN  = 18,
    parameter int ZERO_FILL = 1
) (
    input  logic          Clock,
    input  logic          In,
    mem_ram_init_if.slave bus
);

    localparam int              LAST      = (ZERO_FILL != 0) ? DEPTH - 1 : INIT_LEN - 1;
    localparam logic [ADDR_W:0] LAST_PTR  = (ADDR_W + 1)'(LAST);
    localparam logic [ADDR_W:0] IMG_END   = (ADDR_W + 1)'(INIT_LEN);
    localparam logic [ADDR_W:0] DEPTH_END = (ADDR_W + 1)'(DEPTH);

    state_t            state, state_nx;
    logic [ADDR_W:0]   ptr, ptr_nx;
    logic              q_zero, q_zero_nx;
    logic              qvalid, qvalid_nx;
    logic              reject, reject_nx;

    logic              mem_we, mem_re, in_range;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, core_rdata;

    assign in_range = ({1'b0, bus.Address} < DEPTH_END);

    always_ff @(posedge Clock or negedge In) begin
        if (!In) begin
            state  <= INIT;
            ptr    <= '0;
            q_zero <= 1'b1;
            qvalid <= 1'b0;
            reject <= 1'b0;
        end else begin
            state  <= state_nx;
            ptr    <= ptr_nx;
            q_zero <= q_zero_nx;
            qvalid <= qvalid_nx;
            reject <= reject_nx;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_nx  = state;
        ptr_nx    = ptr;
        q_zero_nx = q_zero;
        qvalid_nx = 1'b0;
        reject_nx = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = bus.Address;
        mem_wdata = bus.D;

        if (bus.Clear) begin
            state_nx  = INIT;
            ptr_nx    = '0;
            reject_nx = bus.Req;
        end else if (state == INIT) begin
            mem_we    = 1'b1;
            mem_addr  = ptr[ADDR_W-1:0];
            mem_wdata = (ptr < IMG_END) ? DATA_W'(img(32'(ptr))) : '0;
            reject_nx = bus.Req;
            if (ptr == LAST_PTR) begin
                state_nx = RUN;
                ptr_nx   = '0;
            end else begin
                ptr_nx = ptr + 1'b1;
            end
        end else if (bus.Req) begin
            if (!in_range) begin
                // Out-of-range reads return zero rather than aliasing into the array.
                reject_nx = 1'b1;
                if (!bus.WE) begin
                    q_zero_nx = 1'b1;
                    qvalid_nx = 1'b1;
                end
            end else if (bus.WE) begin
                mem_we = 1'b1;
            end else begin
                mem_re    = 1'b1;
                q_zero_nx = 1'b0;
                qvalid_nx = 1'b1;
            end
        end
    end

    mem_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .Clock (Clock),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (core_rdata)
    );

    // Q reads zero after reset and after an out-of-range read; otherwise it is the held read register.
    assign bus.Q      = q_zero ? '0 : core_rdata;
    assign bus.QValid = qvalid;
    assign bus.Busy   = (state == INIT);
    assign bus.Reject = reject;

endmodule

// File: tb/tb_mem_ram_init.sv
// Bench for mem_ram_init: three configurations share one stimulus stream and a behavioural model.
module tb_mem_ram_init;

    logic       Clock = 1'b0;
    logic       In;
    logic       clear, req, we;
    logic [4:0] addr;
    logic [7:0] d;

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    mem_ram_init_if #(.DATA_W(8), .ADDR_W(5)) bus0 ();
    mem_ram_init_if #(.DATA_W(8), .ADDR_W(5)) bus1 ();
    mem_ram_init_if #(.DATA_W(8), .ADDR_W(5)) bus2 ();

    assign bus0.Clear = clear;  assign bus1.Clear = clear;  assign bus2.Clear = clear;
    assign bus0.Req   = req;    assign bus1.Req   = req;    assign bus2.Req   = req;
    assign bus0.WE    = we;     assign bus1.WE    = we;     assign bus2.WE    = we;
    assign bus0.Address = addr; assign bus1.Address = addr; assign bus2.Address = addr;
    assign bus0.D     = d;      assign bus1.D     = d;      assign bus2.D     = d;

    // u0: defaults; u1: DEPTH=24; u2: ZERO_FILL=0
    mem_ram_init #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .INIT_LEN(18), .ZERO_FILL(1))
        u0 (.Clock(Clock), .In(In), .bus(bus0));
    mem_ram_init #(.DATA_W(8), .ADDR_W(5), .DEPTH(24), .INIT_LEN(18), .ZERO_FILL(1))
        u1 (.Clock(Clock), .In(In), .bus(bus1));
    mem_ram_init #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .INIT_LEN(18), .ZERO_FILL(0))
        u2 (.Clock(Clock), .In(In), .bus(bus2));

    function automatic logic [7:0] o_q(int c);
        case (c) 0: return bus0.Q; 1: return bus1.Q; default: return bus2.Q; endcase
    endfunction
    function automatic logic o_qv(int c);
        case (c) 0: return bus0.QValid; 1: return bus1.QValid; default: return bus2.QValid; endcase
    endfunction
    function automatic logic o_busy(int c);
        case (c) 0: return bus0.Busy; 1: return bus1.Busy; default: return bus2.Busy; endcase
    endfunction
    function automatic logic o_rej(int c);
        case (c) 0: return bus0.Reject; 1: return bus1.Reject; default: return bus2.Reject; endcase
    endfunction

    // Reference model: whole-image load plus a countdown of remaining busy cycles.
    localparam logic [7:0] IMG [18] = '{8'h80, 8'h3E, 8'h80, 8'h3F, 8'h1E, 8'h7F, 8'hB0, 8'hCC, 8'h1F,
                                        8'h7E, 8'h3F, 8'hC4, 8'h1E, 8'h7F, 8'h3E, 8'hC4, 8'h1E, 8'hFF};

    logic [7:0] m_mem [3][32];
    int         m_busy [3];
    logic [7:0] m_q [3];
    logic       m_qv [3];
    logic       m_rej [3];

    function automatic int cfg_depth(int c);
        return (c == 1) ? 24 : 32;
    endfunction
    function automatic int cfg_fill(int c);
        case (c) 0: return 32; 1: return 24; default: return 18; endcase
    endfunction

    task automatic model_load(int c);
        m_busy[c] = cfg_fill(c);
        for (int i = 0; i < cfg_fill(c); i++) m_mem[c][i] = (i < 18) ? IMG[i] : 8'h00;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            model_load(c);
            m_q[c] = 8'h00; m_qv[c] = 1'b0; m_rej[c] = 1'b0;
        end
    endtask

    task automatic model_step();
        if (!In) begin
            model_reset();
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (clear) begin
                    model_load(c); m_qv[c] = 1'b0; m_rej[c] = req;
                end else if (m_busy[c] > 0) begin
                    m_busy[c]--; m_qv[c] = 1'b0; m_rej[c] = req;
                end else if (!req) begin
                    m_qv[c] = 1'b0; m_rej[c] = 1'b0;
                end else if (int'(addr) >= cfg_depth(c)) begin
                    m_rej[c] = 1'b1;
                    if (we) m_qv[c] = 1'b0;
                    else begin m_q[c] = 8'h00; m_qv[c] = 1'b1; end
                end else begin
                    m_rej[c] = 1'b0;
                    if (we) begin m_mem[c][addr] = d; m_qv[c] = 1'b0; end
                    else begin m_q[c] = m_mem[c][addr]; m_qv[c] = 1'b1; end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge Clock);
        model_step();
        #1;
    endtask

    task automatic idle();
        clear = 1'b0; req = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        req = 1'b1; we = 1'b0; addr = a; step(); idle();
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] v);
        req = 1'b1; we = 1'b1; addr = a; d = v; step(); idle();
    endtask

    task automatic wait_ready();
        int k = 0;
        while ((o_busy(0) || o_busy(1) || o_busy(2)) && k < 100) begin step(); k++; end
        checks++;
        if (o_busy(0) || o_busy(1) || o_busy(2)) begin
            errors++; $display("FAIL wait_ready: Busy still high after %0d cycles, required low", k);
        end
    endtask

    task automatic test_reset();
        In = 1'b0; idle(); addr = '0; d = '0;
        model_reset();
        step(); step();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (o_busy(c) !== 1'b1 || o_qv(c) !== 1'b0 || o_rej(c) !== 1'b0 || o_q(c) !== 8'h00) begin
                errors++;
                $display("FAIL reset u%0d: got busy=%b qv=%b rej=%b q=%h, required 1 0 0 00",
                         c, o_busy(c), o_qv(c), o_rej(c), o_q(c));
            end
        end
    endtask

    task automatic test_preload_len();
        int len [3] = '{-1, -1, -1};
        In = 1'b1;
        for (int k = 1; k <= 100 && (len[0] < 0 || len[1] < 0 || len[2] < 0); k++) begin
            step();
            for (int c = 0; c < 3; c++) if (len[c] < 0 && o_busy(c) === 1'b0) len[c] = k;
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (len[c] !== cfg_fill(c)) begin
                errors++; $display("FAIL preload_len u%0d: Busy cycles %0d, required %0d", c, len[c], cfg_fill(c));
            end
        end
    endtask

    task automatic test_read_image();
        logic [4:0] a_tab [3] = '{5'd1, 5'd17, 5'd30};
        logic [7:0] e_tab [3] = '{8'h3E, 8'hFF, 8'h00};
        for (int i = 0; i < 3; i++) begin
            rd(a_tab[i]);
            checks++;
            if (o_q(0) !== e_tab[i] || o_qv(0) !== 1'b1 || o_rej(0) !== 1'b0) begin
                errors++; $display("FAIL read_image addr %0d: got q=%h qv=%b rej=%b, required q=%h qv=1 rej=0",
                                   a_tab[i], o_q(0), o_qv(0), o_rej(0), e_tab[i]);
            end
        end
        step();
        checks++;
        if (o_qv(0) !== 1'b0 || o_q(0) !== 8'h00) begin
            errors++; $display("FAIL read_hold: got qv=%b q=%h, required qv=0 q=00", o_qv(0), o_q(0));
        end
    endtask

    task automatic test_raw();
        wr(5'd4, 8'h5A);
        checks++;
        if (o_qv(0) !== 1'b0 || o_rej(0) !== 1'b0) begin
            errors++; $display("FAIL write_flags: got qv=%b rej=%b, required 0 0", o_qv(0), o_rej(0));
        end
        rd(5'd4);
        checks++;
        if (o_q(0) !== 8'h5A) begin
            errors++; $display("FAIL raw: got q=%h, required 5a", o_q(0));
        end
        clear = 1'b1; step(); clear = 1'b0;
        wait_ready();
        rd(5'd4);
        checks++;
        if (o_q(0) !== 8'h1E) begin
            errors++; $display("FAIL clear_reload: got q=%h, required 1e", o_q(0));
        end
    endtask

    task automatic test_busy_reject();
        logic [7:0] q_before;
        clear = 1'b1; step(); clear = 1'b0;
        q_before = o_q(0);
        rd(5'd1);
        checks++;
        if (o_rej(0) !== 1'b1 || o_qv(0) !== 1'b0 || o_q(0) !== q_before || o_busy(0) !== 1'b1) begin
            errors++; $display("FAIL busy_reject: got rej=%b qv=%b q=%h busy=%b, required 1 0 %h 1",
                               o_rej(0), o_qv(0), o_q(0), o_busy(0), q_before);
        end
        step();
        checks++;
        if (o_rej(0) !== 1'b0) begin
            errors++; $display("FAIL reject_pulse: got rej=%b, required 0", o_rej(0));
        end
        wait_ready();
        clear = 1'b1; req = 1'b1; we = 1'b0; addr = 5'd2; step(); idle();
        checks++;
        if (o_rej(0) !== 1'b1 || o_qv(0) !== 1'b0 || o_busy(0) !== 1'b1) begin
            errors++; $display("FAIL clear_req: got rej=%b qv=%b busy=%b, required 1 0 1",
                               o_rej(0), o_qv(0), o_busy(0));
        end
        wait_ready();
    endtask

    task automatic test_out_of_range();
        wr(5'd28, 8'h77);
        checks++;
        if (o_rej(1) !== 1'b1 || o_qv(1) !== 1'b0 || o_rej(0) !== 1'b0) begin
            errors++; $display("FAIL oor_write: got u1 rej=%b qv=%b u0 rej=%b, required 1 0 0",
                               o_rej(1), o_qv(1), o_rej(0));
        end
        rd(5'd28);
        checks++;
        if (o_q(1) !== 8'h00 || o_qv(1) !== 1'b1 || o_rej(1) !== 1'b1 || o_q(0) !== 8'h77) begin
            errors++; $display("FAIL oor_read: got u1 q=%h qv=%b rej=%b u0 q=%h, required 00 1 1 77",
                               o_q(1), o_qv(1), o_rej(1), o_q(0));
        end
        rd(5'd20);
        checks++;
        if (o_q(1) !== 8'h00 || o_qv(1) !== 1'b1 || o_rej(1) !== 1'b0) begin
            errors++; $display("FAIL zero_fill: got q=%h qv=%b rej=%b, required 00 1 0", o_q(1), o_qv(1), o_rej(1));
        end
        wr(5'd23, 8'h33);
        rd(5'd23);
        checks++;
        if (o_q(1) !== 8'h33 || o_rej(1) !== 1'b0) begin
            errors++; $display("FAIL last_word: got q=%h rej=%b, required 33 0", o_q(1), o_rej(1));
        end
        rd(5'd24);
        checks++;
        if (o_q(1) !== 8'h00 || o_qv(1) !== 1'b1 || o_rej(1) !== 1'b1) begin
            errors++; $display("FAIL first_oor: got q=%h qv=%b rej=%b, required 00 1 1", o_q(1), o_qv(1), o_rej(1));
        end
    endtask

    task automatic test_reset_mid_preload();
        In = 1'b0; model_reset(); step();
        In = 1'b1;
        for (int i = 0; i < 10; i++) step();
        In = 1'b0; model_reset(); #1;
        checks++;
        if (o_busy(0) !== 1'b1 || o_q(0) !== 8'h00 || o_qv(0) !== 1'b0) begin
            errors++; $display("FAIL async_reset: got busy=%b q=%h qv=%b, required 1 00 0", o_busy(0), o_q(0), o_qv(0));
        end
        step(); step();
        test_preload_len();
        rd(5'd0);
        checks++;
        if (o_q(0) !== 8'h80 || o_qv(0) !== 1'b1) begin
            errors++; $display("FAIL restart_read: got q=%h qv=%b, required 80 1", o_q(0), o_qv(0));
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e_tab [4] = '{8'h80, 8'h3E, 8'h80, 8'h3F};
        for (int a = 0; a < 4; a++) begin
            req = 1'b1; we = 1'b0; addr = 5'(a); step();
            checks++;
            if (o_q(2) !== e_tab[a] || o_qv(2) !== 1'b1) begin
                errors++; $display("FAIL back_to_back addr %0d: got q=%h qv=%b, required %h 1", a, o_q(2), o_qv(2), e_tab[a]);
            end
        end
        idle(); step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 432; i++) begin
            if (i < 32) begin
                clear = 1'b0; req = 1'b1; we = 1'b1; addr = 5'(i); d = 8'($urandom);
            end else begin
                clear = ($urandom_range(31, 0) == 0);
                req   = ($urandom_range(3, 0) != 0);
                we    = 1'($urandom);
                addr  = 5'($urandom_range(31, 0));
                d     = 8'($urandom);
            end
            step();
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (o_q(c) !== m_q[c] || o_qv(c) !== m_qv[c] || o_rej(c) !== m_rej[c] || o_busy(c) !== (m_busy[c] > 0)) begin
                    errors++;
                    $display("FAIL random[%0d] u%0d: got q=%h qv=%b rej=%b busy=%b, required q=%h qv=%b rej=%b busy=%b",
                             i, c, o_q(c), o_qv(c), o_rej(c), o_busy(c), m_q[c], m_qv[c], m_rej[c], m_busy[c] > 0);
                end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_preload_len();
        test_read_image();
        test_raw();
        test_busy_reject();
        test_out_of_range();
        test_reset_mid_preload();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
